// File: rtl/keypad_pkg.sv
// Shared codes, state encodings and small helpers for the 4x4 keypad scanner.
package keypad_pkg;

  localparam logic [3:0] KEY_PLUS  = 4'd10;
  localparam logic [3:0] KEY_MINUS = 4'd11;
  localparam logic [3:0] KEY_MUL   = 4'd12;
  localparam logic [3:0] KEY_DIV   = 4'd13;
  localparam logic [3:0] KEY_EQ    = 4'd15;

  localparam logic [3:0] COL_IDLE  = 4'b1110;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    PRESS_DB = 2'd1,
    HELD     = 2'd2,
    REL_DB   = 2'd3
  } kp_state_e;

  // Lowest-index low bit wins when several rows are pulled down.
  function automatic logic [1:0] low_zero(
    input logic [3:0] v
  );
    logic [1:0] r;
    r = 2'd0;
    priority case (1'b1)
      !v[0]:   r = 2'd0;
      !v[1]:   r = 2'd1;
      !v[2]:   r = 2'd2;
      !v[3]:   r = 2'd3;
      default: r = 2'd0;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] col_rot(
    input logic [3:0] c
  );
    return {c[2:0], c[3]};
  endfunction

endpackage

// File: rtl/keypad_scan_tick_gen.sv
// Free-running column-slot divider: one-cycle tick every DIV clocks.
module scan_tick_gen #(
  parameter int DIV = 50000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick_o
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [W-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == W'(DIV - 1));

  always_comb begin
    cnt_d = cnt_q + W'(1);
    if (tick_o) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/keypad_scan.sv
// 4x4 keypad scanner with press/release debounce and one-cycle key events.
// Optional press beep enabled by defining KEYPAD_BEEP_EN.
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_TICKS = 20,
  parameter int BEEP_CYCLES    = 5000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic       key_down,
  output logic       beep
);

  localparam int CW = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [CW-1:0] DT = CW'(DEBOUNCE_TICKS);

  logic          tick;
  logic [3:0]    sync1_q, sync2_q;
  kp_state_e     state_q, state_d;
  logic [3:0]    col_q, col_d;
  logic [3:0]    cand_q, cand_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_nx;
  logic          kv_q, kv_d;
  logic [3:0]    code_q, code_d;
  logic          down_q, down_d;
  logic          hit;
  logic [1:0]    cidx;

  scan_tick_gen #(
    .DIV(SCAN_DIV)
  ) u_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .tick_o (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 4'hF;
      sync2_q <= 4'hF;
    end else begin
      sync1_q <= row;
      sync2_q <= sync1_q;
    end
  end

  // Only the row of the candidate key on the frozen column is tracked.
  assign hit    = !sync2_q[cand_q[3:2]];
  assign cnt_nx = (cnt_q == DT) ? cnt_q : cnt_q + CW'(1);
  assign cidx   = low_zero(col_q);

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    kv_d    = 1'b0;
    code_d  = code_q;
    down_d  = down_q;
    if (tick) begin
      unique case (state_q)
        SCAN: begin
          if (sync2_q != 4'hF) begin
            cand_d  = {low_zero(sync2_q), cidx};
            cnt_d   = '0;
            state_d = PRESS_DB;
          end else begin
            col_d = col_rot(col_q);
          end
        end
        PRESS_DB: begin
          if (hit) begin
            cnt_d = cnt_nx;
            if (cnt_nx == DT) begin
              kv_d    = 1'b1;
              code_d  = cand_q;
              down_d  = 1'b1;
              state_d = HELD;
            end
          end else begin
            col_d   = col_rot(col_q);
            state_d = SCAN;
          end
        end
        HELD: begin
          if (!hit) begin
            cnt_d   = '0;
            state_d = REL_DB;
          end
        end
        REL_DB: begin
          if (hit) begin
            state_d = HELD;
          end else begin
            cnt_d = cnt_nx;
            if (cnt_nx == DT) begin
              down_d  = 1'b0;
              col_d   = col_rot(col_q);
              state_d = SCAN;
            end
          end
        end
        default: state_d = SCAN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SCAN;
      col_q   <= COL_IDLE;
      cand_q  <= '0;
      cnt_q   <= '0;
      kv_q    <= 1'b0;
      code_q  <= '0;
      down_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      kv_q    <= kv_d;
      code_q  <= code_d;
      down_q  <= down_d;
    end
  end

  assign col       = col_q;
  assign key_valid = kv_q;
  assign key_code  = code_q;
  assign key_down  = down_q;

`ifdef KEYPAD_BEEP_EN
  localparam int BW = $clog2(BEEP_CYCLES + 1);

  logic [BW-1:0] beep_q, beep_d;

  // Loaded on the same edge that raises key_valid; restarts on a new press.
  always_comb begin
    beep_d = beep_q;
    if (kv_d)              beep_d = BW'(BEEP_CYCLES);
    else if (beep_q != '0) beep_d = beep_q - BW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) beep_q <= '0;
    else        beep_q <= beep_d;
  end

  assign beep = (beep_q != '0);
`else
  assign beep = 1'b0;
`endif

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan with a behavioural 4x4 keypad model.
module tb_keypad_scan;
  timeunit 1ns;
  timeprecision 1ps;

  logic       clk;
  logic       rst_n;
  logic [3:0] row;
  logic [3:0] col;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_down;
  logic       beep;

  logic [15:0] pressed;

  int checks;
  int failures;
  int ev_cnt;
  int codes[$];
  int beep_run;
  int beep_last;
  int beep_total;
  logic beep_at_kv;

  keypad_scan #(
    .SCAN_DIV       (4),
    .DEBOUNCE_TICKS (8),
    .BEEP_CYCLES    (20)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .row       (row),
    .col       (col),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_down  (key_down),
    .beep      (beep)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  always_comb begin
    row = 4'hF;
    for (int k = 0; k < 16; k++)
      if (pressed[k] && !col[k%4]) row[k/4] = 1'b0;
  end

  initial begin
    ev_cnt     = 0;
    beep_run   = 0;
    beep_last  = 0;
    beep_total = 0;
    beep_at_kv = 1'b0;
  end

  always @(negedge clk) begin
    if (key_valid === 1'b1) begin
      ev_cnt++;
      codes.push_back(int'(key_code));
      beep_at_kv = beep;
    end
    if (beep === 1'b1) begin
      beep_run++;
      beep_total++;
    end else if (beep_run != 0) begin
      beep_last = beep_run;
      beep_run  = 0;
    end
  end

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tap(input int k);
    pressed[k] = 1'b1;
    #10000;
    pressed[k] = 1'b0;
    #10000;
  endtask

  initial begin
    int e0;
    int seq[4];
    checks   = 0;
    failures = 0;
    pressed  = '0;
    rst_n    = 1'b0;
    #55;
    chk("rst_col", 32'(col), 32'hE);
    chk("rst_kv", 32'(key_valid), 0);
    chk("rst_code", 32'(key_code), 0);
    chk("rst_down", 32'(key_down), 0);
    chk("rst_beep", 32'(beep), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #200;

    // single press of key 1
    e0 = ev_cnt;
    pressed[1] = 1'b1;
    #10000;
    chk("t1_ev", 32'(ev_cnt), 32'(e0 + 1));
    chk("t1_code", 32'(key_code), 1);
    chk("t1_down", 32'(key_down), 1);
    pressed[1] = 1'b0;
    #10000;
    chk("t1_up", 32'(key_down), 0);
    chk("t1_ev2", 32'(ev_cnt), 32'(e0 + 1));

    // sequence 1,10,9,15
    seq = '{1, 10, 9, 15};
    codes.delete();
    e0 = ev_cnt;
    for (int i = 0; i < 4; i++) tap(seq[i]);
    chk("t2_ev", 32'(ev_cnt), 32'(e0 + 4));
    chk("t2_n", 32'(codes.size()), 4);
    for (int i = 0; i < 4; i++)
      if (i < codes.size())
        chk("t2_code", 32'(codes[i]), 32'(seq[i]));

    // short glitch on 13, then a real press
    e0 = ev_cnt;
    pressed[13] = 1'b1;
    #240;
    pressed[13] = 1'b0;
    #2000;
    chk("t3_glitch", 32'(ev_cnt), 32'(e0));
    pressed[13] = 1'b1;
    #10000;
    chk("t3_ev", 32'(ev_cnt), 32'(e0 + 1));
    chk("t3_code", 32'(key_code), 13);
    chk("t3_col", 32'(col), 32'hD);
    pressed[13] = 1'b0;
    #10000;

    // keys 5 and 9 together on column 1
    e0 = ev_cnt;
    pressed[5] = 1'b1;
    pressed[9] = 1'b1;
    #10000;
    chk("t4_ev", 32'(ev_cnt), 32'(e0 + 1));
    chk("t4_code", 32'(key_code), 5);
    pressed[9] = 1'b0;
    #5000;
    chk("t4_ev2", 32'(ev_cnt), 32'(e0 + 1));
    chk("t4_down", 32'(key_down), 1);
    pressed[5] = 1'b0;
    #10000;
    chk("t4_up", 32'(key_down), 0);

    // async reset while 12 is held
    e0 = ev_cnt;
    pressed[12] = 1'b1;
    #5000;
    chk("t5_ev", 32'(ev_cnt), 32'(e0 + 1));
    chk("t5_down", 32'(key_down), 1);
    @(posedge clk);
    #7;
    rst_n = 1'b0;
    #1;
    chk("t5_col", 32'(col), 32'hE);
    chk("t5_kv", 32'(key_valid), 0);
    chk("t5_code", 32'(key_code), 0);
    chk("t5_rdown", 32'(key_down), 0);
    chk("t5_beep", 32'(beep), 0);
    #100;
    @(negedge clk);
    rst_n = 1'b1;
    e0 = ev_cnt;
    #10000;
    chk("t5_ev2", 32'(ev_cnt), 32'(e0 + 1));
    chk("t5_code2", 32'(key_code), 12);
    pressed[12] = 1'b0;
    #10000;

    // beep on press of key 0
    e0 = ev_cnt;
    beep_total = 0;
    tap(0);
    chk("t6_ev", 32'(ev_cnt), 32'(e0 + 1));
    chk("t6_code", 32'(key_code), 0);
`ifdef KEYPAD_BEEP_EN
    chk("t6_beep_kv", 32'(beep_at_kv), 1);
    chk("t6_beep_len", 32'(beep_last), 20);
`else
    chk("t6_beep_off", 32'(beep_total), 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
